// File: rtl/his_peak_builder_if.sv
// rtl/his_peak_builder_if.sv - sample input and peak result handshake bundle; HIS_NEIGHBOR_EN adds peakLeft/peakRight
interface his_peak_builder_if #(
  parameter int TDC_W     = 10,
  parameter int BIN_SHIFT = 5,
  parameter int PIXEL_NUM = 3,
  parameter int CNT_W     = 8
);
  localparam int BIN_W = TDC_W - BIN_SHIFT;
  localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;

  logic             wrEn;
  logic [TDC_W-1:0] data;
  logic             rdy;
  logic             peakValid;
  logic             peakReady;
  logic [PIX_W-1:0] peakPixel;
  logic [BIN_W-1:0] peakBin;
  logic [CNT_W-1:0] peakCount;
  logic             frameDone;
`ifdef HIS_NEIGHBOR_EN
  logic [CNT_W-1:0] peakLeft;
  logic [CNT_W-1:0] peakRight;

  modport master (output wrEn, data, peakReady,
                  input  rdy, peakValid, peakPixel, peakBin, peakCount, frameDone, peakLeft, peakRight);
  modport slave  (input  wrEn, data, peakReady,
                  output rdy, peakValid, peakPixel, peakBin, peakCount, frameDone, peakLeft, peakRight);
`else
  modport master (output wrEn, data, peakReady,
                  input  rdy, peakValid, peakPixel, peakBin, peakCount, frameDone);
  modport slave  (input  wrEn, data, peakReady,
                  output rdy, peakValid, peakPixel, peakBin, peakCount, frameDone);
`endif
endinterface

// File: rtl/his_peak_builder.sv
// rtl/his_peak_builder.sv - per-pixel TDC histogram builder with peak search; HIS_NEIGHBOR_EN adds neighbour bin counts
module his_peak_builder #(
  parameter int TDC_W     = 10,
  parameter int BIN_SHIFT = 5,
  parameter int PIXEL_NUM = 3,
  parameter int ACQ_NUM   = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              res,
  his_peak_builder_if.slave bus
);
  localparam int BIN_W = TDC_W - BIN_SHIFT;
  localparam int NBINS = 2 ** BIN_W;
  localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] hist [PIXEL_NUM][NBINS];
  logic [PIX_W-1:0] pix;
  logic [ACQ_W-1:0] acq;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] max_cnt;
  logic [BIN_W-1:0] max_bin;
  logic [PIX_W-1:0] peak_pix;
  logic [BIN_W-1:0] peak_bin;
  logic [CNT_W-1:0] peak_cnt;

  logic             accept, last_pix, last_acq, last_bin, take;
  logic [BIN_W-1:0] wr_bin, cand_bin;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, cand_cnt;

  assign accept   = bus.wrEn && (state == ACCUM);
  assign last_pix = (pix == PIX_LAST);
  assign last_acq = (acq == ACQ_LAST);
  assign last_bin = (bin == '1);
  assign wr_bin   = bus.data[TDC_W-1:BIN_SHIFT];
  assign wr_cnt   = hist[pix][wr_bin];
  assign rd_cnt   = hist[pix][bin];
  // Bin 0 seeds the running max; later bins win only on strictly greater count
  assign take     = (bin == '0) || (rd_cnt > max_cnt);
  assign cand_cnt = take ? rd_cnt : max_cnt;
  assign cand_bin = take ? bin : max_bin;

`ifdef HIS_NEIGHBOR_EN
  logic [CNT_W-1:0] prev_cnt, run_left, run_right, cand_left, cand_right, peak_left, peak_right;
  logic             cap_right;

  // Right neighbour arrives one bin after the max moves; a max on the last bin has none
  assign cand_left  = take ? ((bin == '0) ? '0 : prev_cnt) : run_left;
  assign cand_right = take ? '0 : (cap_right ? rd_cnt : run_right);
  assign bus.peakLeft  = peak_left;
  assign bus.peakRight = peak_right;
`endif

  assign bus.peakPixel = peak_pix;
  assign bus.peakBin   = peak_bin;
  assign bus.peakCount = peak_cnt;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.rdy       = 1'b0;
    bus.peakValid = 1'b0;
    bus.frameDone = 1'b0;
    case (state)
      ACCUM: begin
        bus.rdy = 1'b1;
        if (accept && last_pix && last_acq) state_nxt = SCAN;
      end
      SCAN: if (last_bin) state_nxt = OUT;
      OUT: begin
        bus.peakValid = 1'b1;
        if (bus.peakReady) begin
          bus.frameDone = last_pix;
          state_nxt     = last_pix ? ACCUM : SCAN;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int p = 0; p < PIXEL_NUM; p++)
        for (int b = 0; b < NBINS; b++)
          hist[p][b] <= '0;
      pix      <= '0;
      acq      <= '0;
      bin      <= '0;
      max_cnt  <= '0;
      max_bin  <= '0;
      peak_pix <= '0;
      peak_bin <= '0;
      peak_cnt <= '0;
`ifdef HIS_NEIGHBOR_EN
      prev_cnt   <= '0;
      run_left   <= '0;
      run_right  <= '0;
      cap_right  <= 1'b0;
      peak_left  <= '0;
      peak_right <= '0;
`endif
    end else begin
      case (state)
        ACCUM: if (accept) begin
          if (wr_cnt != '1) hist[pix][wr_bin] <= wr_cnt + 1'b1;
          if (last_pix) begin
            pix <= '0;
            acq <= last_acq ? '0 : acq + 1'b1;
          end else begin
            pix <= pix + 1'b1;
          end
        end
        SCAN: begin
          hist[pix][bin] <= '0;
          max_cnt        <= cand_cnt;
          max_bin        <= cand_bin;
          bin            <= bin + 1'b1;
`ifdef HIS_NEIGHBOR_EN
          prev_cnt  <= rd_cnt;
          run_left  <= cand_left;
          run_right <= cand_right;
          cap_right <= take;
`endif
          if (last_bin) begin
            peak_pix <= pix;
            peak_bin <= cand_bin;
            peak_cnt <= cand_cnt;
`ifdef HIS_NEIGHBOR_EN
            peak_left  <= cand_left;
            peak_right <= cand_right;
`endif
          end
        end
        OUT: if (bus.peakReady) begin
          if (last_pix) begin
            pix <= '0;
            acq <= '0;
          end else begin
            pix <= pix + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_his_peak_builder.sv
// tb/tb_his_peak_builder.sv - randomized frames checked against a histogram/argmax reference model
module tb_his_peak_builder;
  localparam int TDC_W = 10, BIN_SHIFT = 5, PIXEL_NUM = 3, ACQ_NUM = 2, CNT_W = 8;
  localparam int NBINS = 2 ** (TDC_W - BIN_SHIFT);

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  his_peak_builder_if #(.TDC_W(TDC_W), .BIN_SHIFT(BIN_SHIFT), .PIXEL_NUM(PIXEL_NUM), .CNT_W(CNT_W)) bus ();
  his_peak_builder #(.TDC_W(TDC_W), .BIN_SHIFT(BIN_SHIFT), .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM),
                     .CNT_W(CNT_W)) u_dut (.clk(clk), .res(res), .bus(bus));

  his_peak_builder_if #(.TDC_W(TDC_W), .BIN_SHIFT(BIN_SHIFT), .PIXEL_NUM(PIXEL_NUM), .CNT_W(2)) bus_s ();
  his_peak_builder #(.TDC_W(TDC_W), .BIN_SHIFT(BIN_SHIFT), .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(5),
                     .CNT_W(2)) u_sat (.clk(clk), .res(res), .bus(bus_s));

  int n_tests = 0;
  int n_fail  = 0;
  int codes [ACQ_NUM][PIXEL_NUM];
  int exp_bin [PIXEL_NUM];
  int exp_cnt [PIXEL_NUM];
  int exp_left [PIXEL_NUM];
  int exp_right [PIXEL_NUM];

  function automatic void model();
    int h [NBINS];
    int b;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      for (int k = 0; k < NBINS; k++) h[k] = 0;
      for (int a = 0; a < ACQ_NUM; a++) begin
        b = codes[a][p] >> BIN_SHIFT;
        if (h[b] < (2 ** CNT_W) - 1) h[b]++;
      end
      exp_bin[p] = 0;
      exp_cnt[p] = h[0];
      for (int k = 1; k < NBINS; k++)
        if (h[k] > exp_cnt[p]) begin
          exp_bin[p] = k;
          exp_cnt[p] = h[k];
        end
      exp_left[p]  = (exp_bin[p] > 0) ? h[exp_bin[p] - 1] : 0;
      exp_right[p] = (exp_bin[p] < NBINS - 1) ? h[exp_bin[p] + 1] : 0;
    end
  endfunction

  task automatic fill_random(input int max_code);
    for (int a = 0; a < ACQ_NUM; a++)
      for (int p = 0; p < PIXEL_NUM; p++)
        codes[a][p] = $urandom_range(0, max_code);
  endtask

  task automatic send_frame(input bit gaps);
    for (int a = 0; a < ACQ_NUM; a++)
      for (int p = 0; p < PIXEL_NUM; p++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          bus.wrEn = 1'b0;
          @(posedge clk); #1;
        end
        bus.wrEn = 1'b1;
        bus.data = TDC_W'(codes[a][p]);
        @(posedge clk); #1;
      end
    bus.wrEn = 1'b0;
  endtask

  // Caller arrives just after the accepting edge of the last sample; latency counts that edge as 1
  task automatic collect(input bit chk_lat, input bit stall);
    int cyc;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      cyc = 1;
      if (stall && p == 0) bus.peakReady = 1'b0;
      while (!bus.peakValid && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_tests++;
      if (bus.peakValid !== 1'b1) begin
        n_fail++;
        $display("FAIL valid_timeout pix%0d: peakValid=%b after %0d cycles, required 1", p, bus.peakValid, cyc);
        return;
      end
      if (chk_lat) begin
        n_tests++;
        if (cyc != NBINS + 1) begin
          n_fail++;
          $display("FAIL latency pix%0d: %0d cycles, required %0d", p, cyc, NBINS + 1);
        end
      end
      if (stall && p == 0) begin
        for (int i = 0; i < 10; i++) begin
          bus.wrEn = 1'b1;
          bus.data = TDC_W'($urandom_range(0, 1023));
          @(posedge clk); #1;
          n_tests++;
          if (bus.peakValid !== 1'b1 || bus.rdy !== 1'b0 || bus.peakPixel !== 0 ||
              bus.peakBin !== exp_bin[0] || bus.peakCount !== exp_cnt[0]) begin
            n_fail++;
            $display("FAIL stall_hold cyc%0d: valid=%b rdy=%b pix=%0d bin=%0d cnt=%0d, required 1 0 0 %0d %0d",
                     i, bus.peakValid, bus.rdy, bus.peakPixel, bus.peakBin, bus.peakCount, exp_bin[0], exp_cnt[0]);
          end
        end
        bus.wrEn = 1'b0;
        bus.peakReady = 1'b1;
        #1;
      end
      n_tests++;
      if (bus.peakPixel !== p || bus.peakBin !== exp_bin[p] || bus.peakCount !== exp_cnt[p] ||
          bus.frameDone !== (p == PIXEL_NUM - 1)) begin
        n_fail++;
        $display("FAIL peak pix%0d: pix=%0d bin=%0d cnt=%0d done=%b, required %0d %0d %0d %b",
                 p, bus.peakPixel, bus.peakBin, bus.peakCount, bus.frameDone,
                 p, exp_bin[p], exp_cnt[p], (p == PIXEL_NUM - 1));
      end
`ifdef HIS_NEIGHBOR_EN
      n_tests++;
      if (bus.peakLeft !== exp_left[p] || bus.peakRight !== exp_right[p]) begin
        n_fail++;
        $display("FAIL neighbor pix%0d: left=%0d right=%0d, required %0d %0d",
                 p, bus.peakLeft, bus.peakRight, exp_left[p], exp_right[p]);
      end
`endif
      @(posedge clk); #1;
      n_tests++;
      if (bus.peakValid !== 1'b0 || bus.frameDone !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_drop pix%0d: valid=%b done=%b, required 0 0", p, bus.peakValid, bus.frameDone);
      end
    end
    n_tests++;
    if (bus.rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm: rdy=%b, required 1", bus.rdy);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (bus.rdy !== 1'b1 || bus.peakValid !== 1'b0 || bus.peakPixel !== 0 || bus.peakBin !== 0 ||
        bus.peakCount !== 0 || bus.frameDone !== 1'b0 || bus_s.rdy !== 1'b1 || bus_s.peakValid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b valid=%b pix=%0d bin=%0d cnt=%0d done=%b sat_rdy=%b sat_valid=%b, required 1 0 0 0 0 0 1 0",
               name, bus.rdy, bus.peakValid, bus.peakPixel, bus.peakBin, bus.peakCount, bus.frameDone,
               bus_s.rdy, bus_s.peakValid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    codes[0][0] = 108; codes[0][1] = 511; codes[0][2] = 1022;
    codes[1][0] = 100; codes[1][1] = 500; codes[1][2] = 1000;
    model();
    send_frame(1'b0);
    collect(1'b1, 1'b0);
  endtask

  task automatic test_tie();
    codes[0][0] = 108; codes[0][1] = 0; codes[0][2] = 1000;
    codes[1][0] = 300; codes[1][1] = 0; codes[1][2] = 64;
    model();
    send_frame(1'b0);
    collect(1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      fill_random((f % 2 == 0) ? 127 : 1023);
      model();
      send_frame(1'b1);
      collect(1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    fill_random(1023);
    model();
    send_frame(1'b0);
    collect(1'b0, 1'b1);
    test_basic();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 5 * PIXEL_NUM; i++) begin
      bus_s.wrEn = 1'b1;
      bus_s.data = TDC_W'(64);
      @(posedge clk); #1;
    end
    bus_s.wrEn = 1'b0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      cyc = 0;
      while (!bus_s.peakValid && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_tests++;
      if (bus_s.peakValid !== 1'b1 || bus_s.peakPixel !== p || bus_s.peakBin !== 2 || bus_s.peakCount !== 3) begin
        n_fail++;
        $display("FAIL saturation pix%0d: valid=%b pix=%0d bin=%0d cnt=%0d, required 1 %0d 2 3",
                 p, bus_s.peakValid, bus_s.peakPixel, bus_s.peakBin, bus_s.peakCount, p);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc = 0;
    fill_random(1023);
    send_frame(1'b0);
    while (!bus.peakValid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #3;
    res = 1'b0;
    #1;
    check_idle("reset_mid_scan");
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < ACQ_NUM; a++)
      for (int p = 0; p < PIXEL_NUM; p++)
        codes[a][p] = 0;
    model();
    send_frame(1'b0);
    collect(1'b1, 1'b0);
  endtask

`ifdef HIS_NEIGHBOR_EN
  task automatic test_neighbor();
    codes[0][0] = 96;  codes[0][1] = 1000; codes[0][2] = 0;
    codes[1][0] = 128; codes[1][1] = 1010; codes[1][2] = 40;
    model();
    send_frame(1'b0);
    collect(1'b1, 1'b0);
  endtask
`endif

  initial begin
    bus.wrEn = 1'b0;
    bus.data = '0;
    bus.peakReady = 1'b1;
    bus_s.wrEn = 1'b0;
    bus_s.data = '0;
    bus_s.peakReady = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
`ifdef HIS_NEIGHBOR_EN
    test_neighbor();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
